// File: rtl/rhb_rr_arbit_pkg.sv
// Shared RHB bus constants and arbiter decision encoding.
// Active-low bus levels match the existing RHB blocks.
package rhb_rr_arbit_pkg;

   localparam logic ENABLE_        = 1'b0;
   localparam logic DISABLE_       = 1'b1;
   localparam logic RESET_ENABLE   = 1'b0;
   localparam int   DEF_MAX_TENURE = 16;

   // Which transition rule fired this cycle; first match wins in this order.
   typedef enum logic [2:0] {
      ARB_LOCK_HOLD,
      ARB_SOLE_HOLD,
      ARB_TENURE,
      ARB_FORCED,
      ARB_HANDOFF,
      ARB_PARK
   } arb_case_e;

endpackage

// File: rtl/rhb_rr_pick.sv
// Rotating priority encoder: finds the first requester after the owner,
// wrapping modulo NUM_MASTERS; the owner itself is never a candidate.
module rhb_rr_pick
   import rhb_rr_arbit_pkg::*;
#(
   parameter int NUM_MASTERS = 4
) (
   input  logic [NUM_MASTERS-1:0] m_req_,
   input  logic [2:0]             owner,
   output logic [2:0]             next,
   output logic                   others
);

   always_comb begin
      // NOTE: every output gets a default before the search so no path can infer a latch.
      next   = owner;
      others = 1'b0;
      for (int k = 1; k < NUM_MASTERS; k++) begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!others && ((int'(owner) + k) % NUM_MASTERS) == i && m_req_[i] == ENABLE_) begin
               others = 1'b1;
               next   = 3'(i);
            end
         end
      end
   end

endmodule

// File: rtl/rhb_rr_arbit.sv
// Round-robin RHB bus arbiter with tenure limit, owner lock and idle parking.
// Grant decodes from the registered owner, so requests reach grants one clock later.
module rhb_rr_arbit
   import rhb_rr_arbit_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int MAX_TENURE  = DEF_MAX_TENURE
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] m_req_,
   input  logic [NUM_MASTERS-1:0] m_lock_,
   output logic [NUM_MASTERS-1:0] m_grnt_,
   output logic [2:0]             owner,
   output logic                   arb_switch
);

   localparam int              CNT_W    = $clog2(MAX_TENURE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_TENURE - 1);

   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_sat;
   logic [2:0]       owner_nxt, next;
   logic             own_req, own_lock, others;
   arb_case_e        arb_case;

   rhb_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
      .m_req_ (m_req_),
      .owner  (owner),
      .next   (next),
      .others (others)
   );

   // Only the owner's request and lock bits matter for holding the bus.
   always_comb begin
      own_req  = 1'b0;
      own_lock = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (3'(i) == owner) begin
            own_req  = (m_req_[i]  == ENABLE_);
            own_lock = (m_lock_[i] == ENABLE_);
         end
      end
   end

   always_comb begin
      cnt_sat = (cnt == CNT_LAST) ? cnt : cnt + CNT_W'(1);
      if (own_lock)                   arb_case = ARB_LOCK_HOLD;
      else if (own_req && !others)    arb_case = ARB_SOLE_HOLD;
      else if (own_req && cnt != CNT_LAST) arb_case = ARB_TENURE;
      else if (own_req)               arb_case = ARB_FORCED;
      else if (others)                arb_case = ARB_HANDOFF;
      else                            arb_case = ARB_PARK;

      owner_nxt = owner;
      cnt_nxt   = '0;
      unique case (arb_case)
         ARB_LOCK_HOLD, ARB_SOLE_HOLD: cnt_nxt = cnt_sat;
         ARB_TENURE:                   cnt_nxt = cnt + CNT_W'(1);
         ARB_FORCED, ARB_HANDOFF:      owner_nxt = next;
         default:                      cnt_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (reset == RESET_ENABLE) begin
         owner      <= '0;
         cnt        <= '0;
         arb_switch <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         owner      <= owner_nxt;
         cnt        <= cnt_nxt;
         arb_switch <= (owner_nxt != owner);
      end
   end

   always_comb begin
      m_grnt_ = {NUM_MASTERS{DISABLE_}};
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (3'(i) == owner) m_grnt_[i] = ENABLE_;
      end
   end

endmodule

// File: doc/rhb_rr_arbit.md
Name: rhb_rr_arbit

Overview:
- Round-robin bus arbiter for up to 8 RHB masters; replaces the fixed 2-master sticky arbiter where more requesters share the RHB bus.
- Adds fairness: a tenure counter forces a handoff after MAX_TENURE granted cycles, and a per-master lock holds the bus for atomic sequences.
- Grant is parked on the last owner when the bus is idle; the bus mux selects on owner.

Parameters:
- NUM_MASTERS, 4, number of requesters; legal range 2..8.
- MAX_TENURE, 16, max consecutive granted cycles before a forced handoff; legal range >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- m_req_  in  NUM_MASTERS  request per master, active-low (0 = request)
- m_lock_  in  NUM_MASTERS  lock per master, active-low; only the current owner's bit is honoured
- m_grnt_  out  NUM_MASTERS  grant per master, active-low, exactly one bit 0 at all times
- owner  out  3  index of the current owner
- arb_switch  out  1  active-high; 1 for the single cycle after owner changed

Behaviour:
- State: owner register (3 bits), tenure counter cnt, arb_switch register.
- Reset values: owner = 0, cnt = 0, arb_switch = 0, m_grnt_ = all 1s except bit 0 = 0.
- m_grnt_ decodes combinationally from the owner register. Bit owner = 0; all other bits = 1. Grant therefore follows a request change with one clock of latency.
- Definitions:
  - own_req = m_req_[owner] == 0
  - own_lock = m_lock_[owner] == 0
  - others = any m_req_[i] == 0 with i != owner
- next = first requesting index found searching owner+1, owner+2, … modulo NUM_MASTERS, excluding owner. Only valid when others = 1.
- Transition priority each clk edge, first match wins:
  1. own_lock: owner holds. cnt saturates at MAX_TENURE-1. Lock overrides both req deassertion and tenure expiry.
  2. own_req and not others: owner holds. cnt saturates at MAX_TENURE-1.
  3. own_req and others and cnt < MAX_TENURE-1: owner holds, cnt += 1.
  4. own_req and others and cnt == MAX_TENURE-1: owner <= next, cnt <= 0. This is the forced handoff.
  5. not own_req and others: owner <= next, cnt <= 0.
  6. not own_req and not others: owner holds (parking), cnt <= 0.
- arb_switch <= 1 on edges where owner changes, else 0.
- A lock asserted by a non-owner has no effect; it does not raise priority.
- Simultaneous requests: strict rotation from owner+1. Index order never acts as priority except relative to the current owner.
- Ownership is held for at most MAX_TENURE cycles while others wait, unless locked.
- Reset asserted mid-tenure: owner, cnt and arb_switch return asynchronously to reset values. Grant returns to master 0 immediately.
- Request bits at index >= NUM_MASTERS do not exist; owner never exceeds NUM_MASTERS-1.
- The block has no combinational path from m_req_ to m_grnt_.

Decomposition:
- bus.h holds ENABLE_ (0), DISABLE_ (1), the RESET_ENABLE level, and the default MAX_TENURE constant. The arbiter shares these with the existing bus blocks.
- One combinational sub-module, rhb_rr_pick. Inputs: request vector, current owner. Outputs: next index and an "others" valid flag, implementing the rotate-and-priority-encode.
- The FSM, tenure counter and grant decode stay in rhb_rr_arbit.

Test Plan:
- Reset release, no requests: m_grnt_ = 4'b1110, owner = 0, arb_switch = 0, held for 20 cycles.
- m_req_ = 4'b0101 (masters 1 and 3 requesting) from owner 0 → after 1 edge owner = 1, m_grnt_ = 4'b1101, arb_switch = 1 for 1 cycle. Drop m1 req → owner = 3 next edge.
- Masters 0 and 2 request continuously, MAX_TENURE = 16 → owner alternates 0 → 2 → 0 every 16 cycles. arb_switch pulses every 16 cycles.
- Owner 2 asserts m_lock_[2] = 0 with all others requesting for 40 cycles → owner stays 2 throughout. Release lock → switch to 3 on the next edge.
- Master 3 asserts lock while owner = 1 → no effect. Rotation order 1 → 2 → 3 is preserved.
- Assert reset mid-tenure (owner = 3, cnt = 9) → asynchronously owner = 0, m_grnt_ = 4'b1110, cnt = 0. After release, the tenure count restarts from 0.
